// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe datapath: cell codes, controller
// state encoding and the winning-line codes also used by the checker.
package gato_pkg;

    localparam logic [1:0] CELDA_VACIA = 2'b00;
    localparam logic [1:0] CELDA_P1    = 2'b11;
    localparam logic [1:0] CELDA_P2    = 2'b01;

    localparam logic [3:0] TOTAL_CELDAS = 4'd9;

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        ESPERA   = 2'd1,
        VERIFICA = 2'd2,
        FIN      = 2'd3
    } estado_t;

    typedef enum logic [3:0] {
        LINEA_NINGUNA   = 4'd0,
        LINEA_FILA_SUP  = 4'd1,
        LINEA_FILA_MED  = 4'd2,
        LINEA_FILA_INF  = 4'd3,
        LINEA_COL_IZQ   = 4'd4,
        LINEA_COL_CEN   = 4'd5,
        LINEA_COL_DER   = 4'd6,
        LINEA_DIAG_PRIN = 4'd7,
        LINEA_DIAG_SEC  = 4'd8
    } linea_t;

    function automatic logic [1:0] codigo_jugador(input logic turno);
        return turno ? CELDA_P2 : CELDA_P1;
    endfunction

endpackage

// File: rtl/controlador_tablero_gato_validador.sv
// Combinational move legality check: position must be 1..9 and the target
// cell empty; produces a one-hot write enable for the selected cell.
module validador_movimiento
    import gato_pkg::*;
(
    input  logic [3:0]       mov_pos,
    input  logic [8:0][1:0]  celdas,
    output logic [8:0]       escribe,
    output logic             legal
);

    always_comb begin
        escribe = '0;
        legal   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (mov_pos == 4'(i + 1) && celdas[i] == CELDA_VACIA) begin
                escribe[i] = 1'b1;
                legal      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/controlador_tablero_gato.sv
// Board writer/controller: accepts moves, writes cells, alternates turns,
// requests verification and latches the game result until a new game.
module controlador_tablero_gato
    import gato_pkg::*;
#(
    parameter int VERIF_CICLOS = 2,
    parameter int TIEMPO_TURNO = 0,
    parameter int ANCHO_CONT   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nuevo_juego,
    input  logic       mov_valido,
    input  logic [3:0] mov_pos,
    output logic       mov_listo,
    output logic       mov_rechazado,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       p1_tie,
    output logic [1:0] reg_c1,
    output logic [1:0] reg_c2,
    output logic [1:0] reg_c3,
    output logic [1:0] reg_c4,
    output logic [1:0] reg_c5,
    output logic [1:0] reg_c6,
    output logic [1:0] reg_c7,
    output logic [1:0] reg_c8,
    output logic [1:0] reg_c9,
    output logic       verifica_status,
    output logic       turno,
    output logic       juego_terminado,
    output logic [1:0] ganador,
    output logic       empate
);

    localparam int VW = (VERIF_CICLOS > 1) ? $clog2(VERIF_CICLOS) : 1;
    localparam logic [VW-1:0] ULTIMO_VERIF = VW'(VERIF_CICLOS - 1);
    localparam logic [ANCHO_CONT-1:0] LIMITE_TURNO =
        (TIEMPO_TURNO > 0) ? ANCHO_CONT'(TIEMPO_TURNO - 1) : '0;

    estado_t                estado;
    logic [8:0][1:0]        celdas;
    logic [3:0]             cuenta_mov;
    logic [ANCHO_CONT-1:0]  cont_turno;
    logic [VW-1:0]          cont_verif;
    logic [8:0]             escribe;
    logic                   legal;
    logic                   gana_actual;
    logic                   tablero_lleno;
    logic                   fin_empate;

    validador_movimiento u_validador (
        .mov_pos (mov_pos),
        .celdas  (celdas),
        .escribe (escribe),
        .legal   (legal)
    );

    // Only the moving player's win flag counts; the other one may be stale.
    assign gana_actual   = turno ? p2_win : p1_win;
    assign tablero_lleno = (cuenta_mov == TOTAL_CELDAS);
    // A full board ends the game whether or not the checker reported the tie.
    assign fin_empate    = (p1_tie && tablero_lleno) || tablero_lleno;

    assign reg_c1 = celdas[0];
    assign reg_c2 = celdas[1];
    assign reg_c3 = celdas[2];
    assign reg_c4 = celdas[3];
    assign reg_c5 = celdas[4];
    assign reg_c6 = celdas[5];
    assign reg_c7 = celdas[6];
    assign reg_c8 = celdas[7];
    assign reg_c9 = celdas[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= INICIO;
            celdas          <= '0;
            cuenta_mov      <= '0;
            cont_turno      <= '0;
            cont_verif      <= '0;
            turno           <= 1'b0;
            mov_listo       <= 1'b0;
            mov_rechazado   <= 1'b0;
            verifica_status <= 1'b0;
            juego_terminado <= 1'b0;
            ganador         <= CELDA_VACIA;
            empate          <= 1'b0;
        end else begin
            mov_rechazado <= 1'b0;
            if (nuevo_juego) begin
                estado          <= INICIO;
                celdas          <= '0;
                cuenta_mov      <= '0;
                cont_turno      <= '0;
                cont_verif      <= '0;
                turno           <= 1'b0;
                mov_listo       <= 1'b0;
                verifica_status <= 1'b0;
                juego_terminado <= 1'b0;
                ganador         <= CELDA_VACIA;
                empate          <= 1'b0;
            end else begin
                case (estado)
                    INICIO: begin
                        celdas     <= '0;
                        cuenta_mov <= '0;
                        cont_turno <= '0;
                        mov_listo  <= 1'b1;
                        estado     <= ESPERA;
                    end
                    ESPERA: begin
                        if (mov_valido && mov_listo) begin
                            cont_turno <= '0;
                            if (legal) begin
                                for (int i = 0; i < 9; i++) begin
                                    if (escribe[i]) celdas[i] <= codigo_jugador(turno);
                                end
                                cuenta_mov      <= cuenta_mov + 4'd1;
                                mov_listo       <= 1'b0;
                                verifica_status <= 1'b1;
                                cont_verif      <= '0;
                                estado          <= VERIFICA;
                            end else begin
                                mov_rechazado <= 1'b1;
                            end
                        end else if (TIEMPO_TURNO > 0) begin
                            if (cont_turno == LIMITE_TURNO) begin
                                turno      <= ~turno;
                                cont_turno <= '0;
                            end else begin
                                cont_turno <= cont_turno + 1'b1;
                            end
                        end
                    end
                    VERIFICA: begin
                        if (cont_verif == ULTIMO_VERIF) begin
                            verifica_status <= 1'b0;
                            if (gana_actual) begin
                                juego_terminado <= 1'b1;
                                ganador         <= codigo_jugador(turno);
                                estado          <= FIN;
                            end else if (fin_empate) begin
                                juego_terminado <= 1'b1;
                                empate          <= 1'b1;
                                ganador         <= CELDA_VACIA;
                                estado          <= FIN;
                            end else begin
                                turno     <= ~turno;
                                mov_listo <= 1'b1;
                                estado    <= ESPERA;
                            end
                        end else begin
                            cont_verif <= cont_verif + 1'b1;
                        end
                    end
                    FIN: begin
                        mov_listo <= 1'b0;
                    end
                    default: estado <= INICIO;
                endcase
            end
        end
    end

endmodule
